cmos_watchdog: RTL and testbench
================================

CMOS_WATCHDOG -- requirements
Module: cmos_watchdog

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd4800000: maximum clk_input cycles allowed between vsync rising edges in MONITOR.
REQ-002 Parameter ACK_TIMEOUT, default 24'd65536: maximum cycles to wait in WAIT_ACK for reset_internal_module.
REQ-003 Parameter REQ_LEN, default 8'd16: number of cycles request_reset is held high per request.
REQ-004 Parameter MAX_RETRY, default 4'd3: number of consecutive requests allowed before the block declares failure.
REQ-005 Port clk_input, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port PLL_Lock, input, 1: PLL locked, synchronous to clk_input.
REQ-008 Port reset_internal_module, input, 1: one-cycle pulse issued on sensor reset release; this is the acknowledge.
REQ-009 Port vsync, input, 1: sensor frame sync, asynchronous to clk_input.
REQ-010 Port clear_fail, input, 1: synchronous clear of the FAILED state.
REQ-011 Port request_reset, output, 1: registered request to the reset generator.
REQ-012 Port sensor_fail, output, 1: sticky failure flag.
REQ-013 Port reset_count, output, 8: total requests issued, saturating at 255.
REQ-014 Port wd_state, output, 3: current state encoding.

Function
REQ-015 vsync shall pass through a 2-flop synchronizer and then a rising-edge detector; vs_edge is a one-cycle pulse asserted 3 cycles after the vsync edge.
REQ-016 States shall be IDLE, WAIT_ACK, MONITOR, REQUEST and FAILED, with a single 24-bit cycle counter (cnt) shared by all states.
REQ-017 IDLE: when PLL_Lock=1, go to WAIT_ACK with cnt=0.
REQ-018 WAIT_ACK: cnt increments each cycle.
  - reset_internal_module=1: go to MONITOR, cnt=0.
  - cnt==ACK_TIMEOUT-1: raise a request (REQ-021).
REQ-019 MONITOR: vs_edge clears cnt and clears retry_cnt; otherwise cnt increments, and cnt==TIMEOUT_CYCLES-1 raises a request.
REQ-020 In MONITOR, a vs_edge and a timeout in the same cycle: vs_edge wins and no request is raised.
REQ-021 Raising a request:
  - if retry_cnt==MAX_RETRY, go to FAILED;
  - else go to REQUEST, increment retry_cnt, increment reset_count (saturating), cnt=0.
REQ-022 REQUEST: request_reset=1 for exactly REQ_LEN cycles, then request_reset=0 and go to WAIT_ACK with cnt=0.
REQ-023 reset_internal_module shall be ignored in REQUEST and in FAILED.
REQ-024 reset_internal_module in MONITOR (unsolicited re-reset) shall clear cnt and keep the state.
REQ-025 FAILED: request_reset=0 and sensor_fail=1; the block stays in FAILED until clear_fail=1, which goes to IDLE and clears sensor_fail and retry_cnt in the same cycle.
REQ-026 PLL_Lock=0 in WAIT_ACK, MONITOR or REQUEST shall force IDLE on the next cycle, drop request_reset, and clear cnt; retry_cnt and reset_count are unchanged.
REQ-027 retry_cnt is 4 bits and internal; reset_count never wraps.
REQ-028 All outputs shall be registered, with one cycle of latency from the state decision to the output.

Reset
REQ-029 rst_n=0 shall immediately force:
  - state IDLE;
  - request_reset=0, sensor_fail=0;
  - reset_count=0, retry_cnt=0, cnt=0;
  - synchronizer and edge flops to 0;
  - wd_state=IDLE encoding.
REQ-030 Reset deassertion mid-operation shall restart from IDLE; no state is retained.

Structure
REQ-031 State encodings (IDLE=0, WAIT_ACK=1, MONITOR=2, REQUEST=3, FAILED=4) and the counter width constant shall live in a shared package, cmos_pkg.
REQ-032 The synchronizer and edge detector shall be one sub-module, cmos_sync_edge, with ports clk_input, rst_n, async_in and rise_pulse.
REQ-033 The FSM, counters and output registers shall reside in cmos_watchdog.

Verification
Bench parameters: TIMEOUT_CYCLES=100, ACK_TIMEOUT=50, REQ_LEN=4, MAX_RETRY=3.
REQ-034 PLL_Lock=1, ack pulse at cycle 10, then vsync every 80 cycles for 2000 cycles -> request_reset never asserted, reset_count=0, wd_state=MONITOR.
REQ-035 Ack received, then vsync stops -> request_reset high for exactly 4 cycles starting 100 cycles after the last vs_edge; reset_count=1.
REQ-036 No ack ever -> requests at 50-cycle ack timeouts; after the 3rd request completes and its ack times out, the next request raise goes to FAILED, sensor_fail=1, reset_count=3; clear_fail=1 -> IDLE, sensor_fail=0.
REQ-037 vs_edge coincident with cnt==99 -> no request; cnt=0.
REQ-038 PLL_Lock drops during REQUEST at its 2nd cycle -> request_reset=0 next cycle, wd_state=IDLE.
REQ-039 rst_n asserted in REQUEST -> request_reset=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared encodings and widths for the CMOS sensor watchdog.
package cmos_pkg;

    localparam int CNT_W   = 24;
    localparam int RETRY_W = 4;
    localparam int COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_MONITOR  = 3'd2,
        ST_REQUEST  = 3'd3,
        ST_FAILED   = 3'd4
    } wd_state_e;

    // The request counter must never wrap, so it sticks at all-ones.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector; the pulse
// appears three clocks after the asynchronous input rises.
module cmos_sync_edge
    import cmos_pkg::*;
(
    input  logic clk_input,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign rise_pulse = r_rise;

endmodule

// File: rtl/cmos_watchdog.sv
// Frame-sync watchdog: requests sensor resets when vsync or the reset
// acknowledge goes missing, and latches a failure after too many retries.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for PLL lock
// WAIT_ACK | waiting for reset_internal_module after a (re)start
// MONITOR  | sensor running, vsync edges expected within TIMEOUT_CYCLES
// REQUEST  | request_reset held high for REQ_LEN cycles
// FAILED   | retries exhausted, sensor_fail sticky until clear_fail
module cmos_watchdog
    import cmos_pkg::*;
#(
    parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = 24'd4800000,
    parameter logic [CNT_W-1:0]   ACK_TIMEOUT    = 24'd65536,
    parameter logic [7:0]         REQ_LEN        = 8'd16,
    parameter logic [RETRY_W-1:0] MAX_RETRY      = 4'd3
) (
    input  logic               clk_input,
    input  logic               rst_n,
    input  logic               PLL_Lock,
    input  logic               reset_internal_module,
    input  logic               vsync,
    input  logic               clear_fail,
    output logic               request_reset,
    output logic               sensor_fail,
    output logic [COUNT_W-1:0] reset_count,
    output logic [2:0]         wd_state
);

    wd_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic [COUNT_W-1:0] r_count;
    logic               r_req;
    logic               r_fail;

    wd_state_e          w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [RETRY_W-1:0] w_nxt_retry;
    logic [COUNT_W-1:0] w_nxt_count;
    logic               w_raise;
    logic               w_vs_edge;

    cmos_sync_edge u_vsync_edge (
        .clk_input  (clk_input),
        .rst_n      (rst_n),
        .async_in   (vsync),
        .rise_pulse (w_vs_edge)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_retry = r_retry;
        w_nxt_count = r_count;
        w_raise     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (PLL_Lock) begin
                    w_nxt_state = ST_WAIT_ACK;
                    w_nxt_cnt   = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (reset_internal_module) begin
                    w_nxt_state = ST_MONITOR;
                    w_nxt_cnt   = '0;
                end else if (r_cnt == ACK_TIMEOUT - CNT_W'(1)) begin
                    w_raise = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_MONITOR: begin
                // A frame edge beats a coincident timeout.
                if (w_vs_edge) begin
                    w_nxt_cnt   = '0;
                    w_nxt_retry = '0;
                end else if (reset_internal_module) begin
                    w_nxt_cnt = '0;
                end else if (r_cnt == TIMEOUT_CYCLES - CNT_W'(1)) begin
                    w_raise = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_REQUEST: begin
                if (r_cnt == {16'd0, REQ_LEN - 8'd1}) begin
                    w_nxt_state = ST_WAIT_ACK;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_FAILED: begin
                if (clear_fail) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_retry = '0;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase

        if (w_raise) begin
            w_nxt_cnt = '0;
            if (r_retry == MAX_RETRY) begin
                w_nxt_state = ST_FAILED;
            end else begin
                w_nxt_state = ST_REQUEST;
                w_nxt_retry = r_retry + RETRY_W'(1);
                w_nxt_count = sat_inc(r_count);
            end
        end

        // Losing lock aborts everything in flight but keeps the history counters.
        if (!PLL_Lock && (r_state == ST_WAIT_ACK || r_state == ST_MONITOR ||
                          r_state == ST_REQUEST)) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_retry = r_retry;
            w_nxt_count = r_count;
        end
    end

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_retry <= '0;
            r_count <= '0;
            r_req   <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_retry <= w_nxt_retry;
            r_count <= w_nxt_count;
            r_req   <= (w_nxt_state == ST_REQUEST);
            r_fail  <= (w_nxt_state == ST_FAILED);
        end
    end

    assign request_reset = r_req;
    assign sensor_fail   = r_fail;
    assign reset_count   = r_count;
    assign wd_state      = r_state;

endmodule

// File: tb/tb_cmos_watchdog.sv
// Directed bench for cmos_watchdog; expected request start cycles are
// queued when stimulus is applied and matched when request_reset rises.
module tb_cmos_watchdog;

    localparam int TO  = 100;
    localparam int ACK = 50;
    localparam int RL  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       ack;
    logic       vsync;
    logic       clr;
    logic       request_reset;
    logic       sensor_fail;
    logic [7:0] reset_count;
    logic [2:0] wd_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    cmos_watchdog #(
        .TIMEOUT_CYCLES (24'd100),
        .ACK_TIMEOUT    (24'd50),
        .REQ_LEN        (8'd4),
        .MAX_RETRY      (4'd3)
    ) dut (
        .clk_input             (clk),
        .rst_n                 (rst_n),
        .PLL_Lock              (lock),
        .reset_internal_module (ack),
        .vsync                 (vsync),
        .clear_fail            (clr),
        .request_reset         (request_reset),
        .sensor_fail           (sensor_fail),
        .reset_count           (reset_count),
        .wd_state              (wd_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=%0d expected=<done>", cyc);
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for request_reset to rise and matches the cycle against the queue head.
    task automatic wait_req(input string tag, input int budget);
        bit got = 0;
        int exp_cyc;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (request_reset === 1'b1) got = 1;
        end
        exp_cyc = exp_q.pop_front();
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got) check({tag, "_start"}, cyc, exp_cyc);
    endtask

    // Counts consecutive high samples starting at the current one.
    task automatic measure_len(input string tag);
        int len = 0;
        for (int i = 0; i < 20; i++) begin
            if (request_reset !== 1'b1) break;
            len++;
            tick();
        end
        check({tag, "_len"}, len, RL);
    endtask

    initial begin
        int  cv;
        int  a;
        int  c0;
        int  tfail;
        bit  seen;

        rst_n = 1'b0; lock = 1'b0; ack = 1'b0; vsync = 1'b0; clr = 1'b0;
        ticks(3);
        check("rst_req", request_reset, 0);
        check("rst_fail", sensor_fail, 0);
        check("rst_count", reset_count, 0);
        check("rst_state", wd_state, 0);
        rst_n = 1'b1;
        tick();
        check("idle_nolock", wd_state, 0);

        // Healthy sensor: ack then regular frames, never a request.
        lock = 1'b1;
        tick();
        check("lock_wait_ack", wd_state, 1);
        ticks(8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_monitor", wd_state, 2);
        seen = 0;
        cv = 0;
        for (int k = 0; k < 25; k++) begin
            vsync = 1'b1;
            cv = cyc;
            for (int i = 0; i < 4; i++) begin tick(); seen |= request_reset; end
            vsync = 1'b0;
            for (int i = 0; i < 76; i++) begin tick(); seen |= request_reset; end
        end
        check("healthy_no_req", 32'(seen), 0);
        check("healthy_count", reset_count, 0);
        check("healthy_state", wd_state, 2);

        // Frames stop: cnt cleared on the edge where vs_edge is consumed
        // (cv+4), times out at cnt=99, request registered one edge later.
        exp_q.push_back(cv + 4 + TO);
        wait_req("vs_timeout", 200);
        check("vs_timeout_count", reset_count, 1);
        measure_len("vs_timeout");
        check("after_req_wait_ack", wd_state, 1);

        // vs_edge lands exactly on cnt==99: no request, cnt restarts.
        ack = 1'b1;
        a = cyc;
        tick();
        ack = 1'b0;
        check("reack_monitor", wd_state, 2);
        ticks(96);
        vsync = 1'b1;
        exp_q.push_back(a + 1 + TO + TO);
        ticks(2);
        vsync = 1'b0;
        ticks(51);
        check("coincide_no_req", request_reset, 0);
        check("coincide_state", wd_state, 2);
        wait_req("coincide_next", 100);
        check("coincide_count", reset_count, 2);

        // Lock lost in the second REQUEST cycle.
        tick();
        check("lockdrop_req_hi", request_reset, 1);
        lock = 1'b0;
        tick();
        check("lockdrop_req", request_reset, 0);
        check("lockdrop_state", wd_state, 0);
        check("lockdrop_count", reset_count, 2);

        // Async reset in REQUEST clears outputs without a clock edge.
        lock = 1'b1;
        exp_q.push_back(cyc + 1 + ACK);
        wait_req("relock_ack_to", 100);
        check("relock_count", reset_count, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", request_reset, 0);
        check("async_rst_state", wd_state, 0);
        check("async_rst_count", reset_count, 0);
        tick();
        lock = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", wd_state, 0);

        // No ack ever: three requests, then FAILED on the next raise.
        lock = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back(c0 + 1 + ACK + k * (RL + ACK));
        for (int k = 0; k < 3; k++) begin
            wait_req($sformatf("noack%0d", k), 100);
            measure_len($sformatf("noack%0d", k));
        end
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (sensor_fail === 1'b1) seen = 1;
        end
        check("fail_seen", 32'(seen), 1);
        tfail = c0 + 1 + ACK + 3 * (RL + ACK);
        check("fail_cycle", cyc, tfail);
        check("fail_count", reset_count, 3);
        check("fail_state", wd_state, 4);
        check("fail_req_low", request_reset, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("fail_ignores_ack", wd_state, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_state", wd_state, 0);
        check("clear_fail_flag", sensor_fail, 0);

        // retry count cleared: next raise is a request, not FAILED.
        exp_q.push_back(cyc + 1 + ACK);
        wait_req("after_clear", 100);
        check("after_clear_count", reset_count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
